// File: rtl/vga_fetch_arbiter_pkg.sv
// Shared VGA fetch definitions: state encoding, coordinate-block geometry and
// the fetch address offset helper.
package vga_fetch_arbiter_pkg;

  localparam logic [15:0] BASE_ADDR_DEFAULT = 16'h3F00;
  localparam int unsigned FETCH_WORDS       = 6;
  localparam logic [2:0]  LAST_IDX          = 3'(FETCH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } fetch_state_e;

  typedef logic [15:0] coord_t;

  // The final fetch cycle only collects data, so its address stays on the last word.
  function automatic logic [15:0] fetch_offset(input logic [2:0] idx);
    if (idx >= LAST_IDX) return 16'(FETCH_WORDS - 1);
    return {13'd0, idx};
  endfunction

endpackage

// File: rtl/vga_coord_shadow.sv
// Shadow bank for sprite coordinates: words are captured one at a time during a
// fetch and all six become visible together on the commit strobe.
module vga_coord_shadow
  import vga_fetch_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cap_en,
  input  logic [2:0] cap_idx,
  input  coord_t     cap_data,
  input  logic       commit,
  output coord_t     mx,
  output coord_t     my,
  output coord_t     p1x,
  output coord_t     p1y,
  output coord_t     p2x,
  output coord_t     p2y
);

  coord_t shadow_q [FETCH_WORDS];
  coord_t coord_q  [FETCH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '{default: '0};
      coord_q  <= '{default: '0};
    end else begin
      if (cap_en && (cap_idx < LAST_IDX)) shadow_q[cap_idx] <= cap_data;
      if (commit) coord_q <= shadow_q;
    end
  end

  assign mx  = coord_q[0];
  assign my  = coord_q[1];
  assign p1x = coord_q[2];
  assign p1y = coord_q[3];
  assign p2x = coord_q[4];
  assign p2y = coord_q[5];

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Arbitrates a single synchronous memory port between CPU accesses and the
// per-frame sprite-coordinate fetch triggered by vblank_start.
module vga_fetch_arbiter
  import vga_fetch_arbiter_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank_start,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_grant,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mx,
  output logic [15:0] my,
  output logic [15:0] p1x,
  output logic [15:0] p1y,
  output logic [15:0] p2x,
  output logic [15:0] p2y,
  output logic        frame_valid
);

  fetch_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic         pending_q, pending_d;
  logic         rd_pend_q;
  logic         frame_valid_q;
  logic         cap_en;
  logic         commit;
  logic [15:0]  fetch_addr;

  assign fetch_addr = BASE_ADDR + fetch_offset(idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      rd_pend_q     <= cpu_grant & ~cpu_we;
      frame_valid_q <= commit;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q | vblank_start;
    cpu_grant = 1'b0;
    mem_addr  = fetch_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    cap_en    = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q || vblank_start) begin
          // A pulse arriving on this cycle is absorbed by the fetch it starts.
          state_d   = ST_FETCH;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          cpu_grant = cpu_req;
          mem_addr  = cpu_addr;
          mem_we    = cpu_req & cpu_we;
        end
      end
      ST_FETCH: begin
        cap_en = (idx_q != 3'd0);
        idx_d  = idx_q + 3'd1;
        if (idx_q == LAST_IDX) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_rvalid  = rd_pend_q;
  assign cpu_rdata   = rd_pend_q ? mem_rdata : '0;
  assign frame_valid = frame_valid_q;

  vga_coord_shadow u_shadow (
    .clk      (clk),
    .reset    (reset),
    .cap_en   (cap_en),
    .cap_idx  (idx_q - 3'd1),
    .cap_data (mem_rdata),
    .commit   (commit),
    .mx       (mx),
    .my       (my),
    .p1x      (p1x),
    .p1y      (p1y),
    .p2x      (p2x),
    .p2y      (p2y)
  );

endmodule
